// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute stage: opcode encodings and result FIFO depth.
// No logic lives here; alu_exec_stage and alu_func_unit import it.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ID   = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/alu_func_unit.sv
// Combinational ALU: result and signed-overflow flag from opcode and operands.
// Zero latency, no state, no flow control.
module alu_func_unit
  import alu_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic [2:0]            _op,
  input  logic [data_width-1:0] _A,
  input  logic [data_width-1:0] _B,
  output logic [data_width-1:0] _C,
  output logic                  _O
);

  localparam int MSB = data_width - 1;

  logic [data_width:0] b_ext;
  logic [data_width:0] b_neg;

  // Negate B one bit wider so that -(most-negative) keeps a positive sign;
  // its low bits still equal ~B+1 for the modular subtraction.
  always_comb begin
    b_ext = {_B[MSB], _B};
    b_neg = ~b_ext + {{data_width{1'b0}}, 1'b1};
  end

  always_comb begin
    _C = '0;
    _O = 1'b0;
    case (_op)
      OP_ADD: begin
        _C = _A + _B;
        _O = (_A[MSB] == _B[MSB]) && (_C[MSB] != _A[MSB]);
      end
      OP_SUB: begin
        _C = _A + b_neg[MSB:0];
        _O = (_A[MSB] == b_neg[data_width]) && (_C[MSB] != _A[MSB]);
      end
      OP_ID:   _C = _A;
      OP_NOT:  _C = ~_A;
      OP_AND:  _C = _A & _B;
      OP_OR:   _C = _A | _B;
      OP_NAND: _C = ~(_A & _B);
      OP_NOR:  _C = ~(_A | _B);
      default: _C = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: result lands in a 2-entry FIFO, out_valid one cycle after push; in_ready drops when full.
// Define ALU_EXEC_STAGE_STATS_EN to add the saturating op_count output.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            _op,
  input  logic [data_width-1:0] _A,
  input  logic [data_width-1:0] _B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] _C,
  output logic                  _O,
  input  logic                  clr_sticky,
  output logic                  ovf_sticky
`ifdef ALU_EXEC_STAGE_STATS_EN
  ,
  output logic [15:0]           op_count
`endif
);

  localparam int EW = data_width + 1;

  logic [data_width-1:0] fu_c;
  logic                  fu_o;

  alu_func_unit #(.data_width(data_width)) u_func (
    ._op (_op),
    ._A  (_A),
    ._B  (_B),
    ._C  (fu_c),
    ._O  (fu_o)
  );

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          sticky_q, sticky_d;
  logic          push, pop;
  logic [EW-1:0] head;

  assign in_ready  = (count_q < 2'(FIFO_DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign head      = mem_q[rd_ptr_q];
  assign _C        = out_valid ? head[EW-1:1] : '0;
  assign _O        = out_valid ? head[0] : 1'b0;
  assign ovf_sticky = sticky_q;

  always_comb begin
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    sticky_d = sticky_q;
    if (push) mem_d[wr_ptr_q] = {fu_c, fu_o};
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (clr_sticky) sticky_d = 1'b0;
    if (push && fu_o) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sticky_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef ALU_EXEC_STAGE_STATS_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  // A push on the same edge as clr_sticky still counts.
  always_comb begin
    op_cnt_d = op_cnt_q;
    if (clr_sticky) op_cnt_d = 16'd0;
    if (push) op_cnt_d = (op_cnt_q == 16'hFFFF) ? 16'hFFFF : op_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) op_cnt_q <= 16'd0;
    else       op_cnt_q <= op_cnt_d;
  end

  assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: arithmetic/logic vectors, FIFO backpressure,
// sticky overflow priority and asynchronous reset with a full FIFO.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c;
  logic        o;
  logic        clr_sticky;
  logic        ovf_sticky;
`ifdef ALU_EXEC_STAGE_STATS_EN
  logic [15:0] op_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.data_width(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    ._op        (op),
    ._A         (a),
    ._B         (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    ._C         (c),
    ._O         (o),
    .clr_sticky (clr_sticky),
    .ovf_sticky (ovf_sticky)
`ifdef ALU_EXEC_STAGE_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] p, input logic [15:0] x, input logic [15:0] y);
    in_valid = v;
    op       = p;
    a        = x;
    b        = y;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, c;
    logic        o;
  } vec_t;

  vec_t vecs[11] = '{
    '{3'b000, 16'h1234, 16'h1111, 16'h2345, 1'b0},
    '{3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1},
    '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b1},
    '{3'b001, 16'h0005, 16'h0007, 16'hFFFE, 1'b0},
    '{3'b001, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0},
    '{3'b010, 16'hA5A5, 16'h1234, 16'hA5A5, 1'b0},
    '{3'b011, 16'h00FF, 16'hFFFF, 16'hFF00, 1'b0},
    '{3'b100, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0},
    '{3'b101, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0},
    '{3'b110, 16'h0F0F, 16'h0FF0, 16'hF0FF, 1'b0},
    '{3'b111, 16'h1200, 16'h0034, 16'hEDCB, 1'b0}
  };

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_c", {16'b0, c}, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_o", {31'b0, o}, 32'd0);
    chk("rst_sticky", {31'b0, ovf_sticky}, 32'd0);

    // Overflowing ADD, then SUB of most-negative pushed while the ADD pops.
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 16'h7FFF, 16'h0001);
    tick();
    chk("add_ovf_valid", {31'b0, out_valid}, 32'd1);
    chk("add_ovf_c", {16'b0, c}, 32'h8000);
    chk("add_ovf_o", {31'b0, o}, 32'd1);
    chk("add_ovf_sticky", {31'b0, ovf_sticky}, 32'd1);
    drive(1'b1, 3'b001, 16'h0000, 16'h8000);
    tick();
    chk("sub_min_valid", {31'b0, out_valid}, 32'd1);
    chk("sub_min_c", {16'b0, c}, 32'h8000);
    chk("sub_min_o", {31'b0, o}, 32'd1);
    drive(1'b1, 3'b110, 16'hFFFF, 16'h00FF);
    tick();
    chk("nand_c", {16'b0, c}, 32'hFF00);
    chk("nand_o", {31'b0, o}, 32'd0);
    chk("nand_in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_c", {16'b0, c}, 32'h0);

    // Streaming table: each push overlaps the pop of the previous result.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      chk($sformatf("vec%0d_c", i), {16'b0, c}, {16'b0, vecs[i].c});
      chk($sformatf("vec%0d_o", i), {31'b0, o}, {31'b0, vecs[i].o});
    end
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    tick();

    // Sticky: clear alone, then clear colliding with an overflowing push.
    clr_sticky = 1'b1;
    tick();
    chk("clr_alone", {31'b0, ovf_sticky}, 32'd0);
    drive(1'b1, 3'b000, 16'h4000, 16'h4000);
    tick();
    chk("clr_vs_set", {31'b0, ovf_sticky}, 32'd1);
    chk("clr_vs_set_c", {16'b0, c}, 32'h8000);
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    tick();
    chk("clr_after", {31'b0, ovf_sticky}, 32'd0);
    clr_sticky = 1'b0;

    // Backpressure: three pushes into a stalled 2-entry FIFO.
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 16'd1, 16'h0);
    tick();
    chk("bp1_in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 3'b010, 16'd2, 16'h0);
    tick();
    chk("bp2_in_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 3'b010, 16'd3, 16'h0);
    tick();
    chk("bp3_held", {31'b0, in_ready}, 32'd0);
    chk("bp3_head", {16'b0, c}, 32'd1);
    tick();
    chk("bp_stable", {16'b0, c}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_out2", {16'b0, c}, 32'd2);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp_out3", {16'b0, c}, 32'd3);
    chk("bp_out3_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    tick();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Reset mid-cycle with the FIFO full.
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 16'd7, 16'h0);
    tick();
    drive(1'b1, 3'b010, 16'd8, 16'h0);
    tick();
    chk("full_before_rst", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_c", {16'b0, c}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 3'b010, 16'd9, 16'h0);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    chk("post_rst_head", {16'b0, c}, 32'd9);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter data_width, default 16, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation offered this cycle.
REQ-005 SHALL have port in_ready  output  1  stage can accept an operation.
REQ-006 SHALL have port _op  input  3  opcode: 000 ADD, 001 SUB, 010 ID, 011 NOT, 100 AND, 101 OR, 110 NAND, 111 NOR.
REQ-007 SHALL have ports _A and _B  input  data_width  each  operands.
REQ-008 SHALL have port out_valid  output  1  result at the buffer head is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head this cycle.
REQ-010 SHALL have port _C  output  data_width  result at the buffer head.
REQ-011 SHALL have port _O  output  1  signed-overflow flag of the head result.
REQ-012 SHALL have port clr_sticky  input  1  clears the sticky overflow bit.
REQ-013 SHALL have port ovf_sticky  output  1  set by any accepted ADD/SUB that overflowed.

Function
REQ-014 SHALL accept an operation on a clock edge where in_valid and in_ready are both 1 (push).
REQ-015 SHALL retire the head on a clock edge where out_valid and out_ready are both 1 (pop).
REQ-016 SHALL compute the result combinationally from _op, _A and _B, and write {_C,_O} into a 2-entry result FIFO on push.
- Latency: out_valid rises the cycle after the push edge when the FIFO was empty.
REQ-017 SHALL compute ADD as _A+_B and SUB as _A-_B, both modulo 2^data_width.
REQ-018 SHALL set _O for ADD/SUB when both effective operands have equal sign bits and the result sign differs; for SUB the effective second operand is the two's complement of _B.
- Effective second operand for SUB = ~_B+1, including _B = most-negative value.
REQ-019 SHALL give ID=_A, NOT=~_A, AND=_A&_B, OR=_A|_B, NAND=~(_A&_B), NOR=~(_A|_B), each with _O=0.
REQ-020 SHALL drive in_ready = (count < 2); count is the FIFO occupancy, 0..2.
REQ-021 SHALL update count on a simultaneous push and pop (possible only at count 1) as follows:
- count stays 1; the new entry becomes the head on the next cycle.
REQ-022 SHALL drive out_valid = (count != 0); _C and _O SHALL be 0 when count = 0.
REQ-023 SHALL hold the head _C/_O stable while out_valid=1 and out_ready=0.
REQ-024 SHALL set ovf_sticky on any push whose _O=1 and clear it on clr_sticky=1; set wins when both occur on the same edge.
REQ-025 SHALL wrap the FIFO read and write pointers modulo 2 without loss or duplication.

Reset
REQ-026 SHALL, on reset assertion (including mid-operation), immediately force:
- count=0, pointers=0, out_valid=0, _C=0, _O=0, ovf_sticky=0;
- in_ready=1 after reset deassertion.
- Any in-flight operation is discarded.

Configuration
REQ-027 SHALL, with ALU_EXEC_STAGE_STATS_EN defined, add output op_count (16 bits):
- counts pushes and saturates at 16'hFFFF;
- resets to 0;
- is cleared by clr_sticky with the same priority as REQ-024 (push wins).
REQ-028 SHALL, without ALU_EXEC_STAGE_STATS_EN, have no op_count port and no counter logic.

Structure
REQ-029 SHALL take opcode constants (ADD..NOR) and the FIFO depth constant 2 from shared package alu_pkg.
REQ-030 SHALL place the combinational compute in a sub-module alu_func_unit (data_width, _op, _A, _B -> _C, _O); FIFO and handshake logic stay in alu_exec_stage.

Verification
REQ-031 SHALL cover ADD 16'h7FFF+16'h0001, out_ready=1 -> next cycle out_valid=1, _C=16'h8000, _O=1, ovf_sticky=1.
REQ-032 SHALL cover SUB 16'h0000-16'h8000 -> _C=16'h8000, _O=1; then NAND 16'hFFFF,16'h00FF -> _C=16'hFF00, _O=0.
REQ-033 SHALL cover out_ready=0, three back-to-back pushes (ID 1, ID 2, ID 3) -> in_ready=0 after two pushes, third held; releasing out_ready yields 1, 2, 3 in order with no gaps beyond one cycle.
REQ-034 SHALL cover count=1, push and pop on the same edge -> count stays 1, next _C equals the pushed result.
REQ-035 SHALL cover clr_sticky=1 on the same edge as an overflowing ADD -> ovf_sticky=1; clr_sticky alone next edge -> ovf_sticky=0.
REQ-036 SHALL cover reset asserted with count=2 mid-cycle -> out_valid=0 and _C=0 immediately; in_ready=1 after deassertion.
